// File: rtl/rtc_counter_if.sv
// Signal bundle between the time-set editor (master) and the time-of-day counter (slave).
// Alarm signals exist only when RTC_ALARM_EN is defined.
interface rtc_counter_if;
    logic        HOLD;
    logic        TIME_SET_FLAG;
    logic [17:0] TIME_SETDATA;
    logic [17:0] CLOCK_DATA;
    logic        SEC_TICK;
    logic        DAY_ROLLOVER;
    logic        LOAD_ACK;
`ifdef RTC_ALARM_EN
    logic [17:0] ALARM_DATA;
    logic        ALARM_ARM;
    logic        ALARM_MATCH;

    modport master (
        output HOLD, TIME_SET_FLAG, TIME_SETDATA, ALARM_DATA, ALARM_ARM,
        input  CLOCK_DATA, SEC_TICK, DAY_ROLLOVER, LOAD_ACK, ALARM_MATCH
    );
    modport slave (
        input  HOLD, TIME_SET_FLAG, TIME_SETDATA, ALARM_DATA, ALARM_ARM,
        output CLOCK_DATA, SEC_TICK, DAY_ROLLOVER, LOAD_ACK, ALARM_MATCH
    );
`else
    modport master (
        output HOLD, TIME_SET_FLAG, TIME_SETDATA,
        input  CLOCK_DATA, SEC_TICK, DAY_ROLLOVER, LOAD_ACK
    );
    modport slave (
        input  HOLD, TIME_SET_FLAG, TIME_SETDATA,
        output CLOCK_DATA, SEC_TICK, DAY_ROLLOVER, LOAD_ACK
    );
`endif
endinterface

// File: rtl/rtc_counter.sv
// Purpose: free-running hh:mm:ss counter with prescaler, edge-triggered load; optional alarm (RTC_ALARM_EN).
// Latency: load visible 1 cycle after TIME_SET_FLAG rises; all outputs registered.
// Backpressure: none; HOLD freezes prescaler and time, loads are still accepted.
module rtc_counter #(
    parameter int TICKS_PER_SEC = 1000000,
    parameter int PRESC_W       = 20
) (
    input  logic         CLK,
    input  logic         RESET,
    rtc_counter_if.slave bus
);

    typedef struct packed {
        logic [5:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } tod_t;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

    tod_t               cur_q;
    tod_t               set_tod;
    tod_t               load_tod;
    tod_t               inc_tod;
    logic [PRESC_W-1:0] presc_q;
    logic               flag_prev_q;
    logic               sec_tick_q;
    logic               day_roll_q;
    logic               load_ack_q;
    logic               load_req;
    logic               tick;
    logic               day_wrap;

    assign load_req = bus.TIME_SET_FLAG & ~flag_prev_q;
    assign tick     = ~bus.HOLD & (presc_q == PRESC_MAX);

    // Each field is sanitised on its own so a single bad field does not wipe the others.
    always_comb begin
        set_tod       = tod_t'(bus.TIME_SETDATA);
        load_tod.hour = (set_tod.hour > 6'd23) ? 6'd0 : set_tod.hour;
        load_tod.min  = (set_tod.min  > 6'd59) ? 6'd0 : set_tod.min;
        load_tod.sec  = (set_tod.sec  > 6'd59) ? 6'd0 : set_tod.sec;
    end

    always_comb begin
        inc_tod  = cur_q;
        day_wrap = 1'b0;
        if (cur_q.sec == 6'd59) begin
            inc_tod.sec = 6'd0;
            if (cur_q.min == 6'd59) begin
                inc_tod.min = 6'd0;
                if (cur_q.hour == 6'd23) begin
                    inc_tod.hour = 6'd0;
                    day_wrap     = 1'b1;
                end else begin
                    inc_tod.hour = cur_q.hour + 6'd1;
                end
            end else begin
                inc_tod.min = cur_q.min + 6'd1;
            end
        end else begin
            inc_tod.sec = cur_q.sec + 6'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cur_q       <= '0;
            presc_q     <= '0;
            flag_prev_q <= 1'b0;
            sec_tick_q  <= 1'b0;
            day_roll_q  <= 1'b0;
            load_ack_q  <= 1'b0;
        end else begin
            flag_prev_q <= bus.TIME_SET_FLAG;
            sec_tick_q  <= 1'b0;
            day_roll_q  <= 1'b0;
            load_ack_q  <= 1'b0;
            if (load_req) begin
                // A tick landing on the load cycle is dropped; the new second starts fresh.
                cur_q      <= load_tod;
                presc_q    <= '0;
                load_ack_q <= 1'b1;
            end else if (!bus.HOLD) begin
                if (tick) begin
                    presc_q    <= '0;
                    cur_q      <= inc_tod;
                    sec_tick_q <= 1'b1;
                    day_roll_q <= day_wrap;
                end else begin
                    presc_q <= presc_q + PRESC_W'(1);
                end
            end
        end
    end

    assign bus.CLOCK_DATA   = cur_q;
    assign bus.SEC_TICK     = sec_tick_q;
    assign bus.DAY_ROLLOVER = day_roll_q;
    assign bus.LOAD_ACK     = load_ack_q;

`ifdef RTC_ALARM_EN
    logic alarm_match_q;

    // sec_tick_q marks the cycle where CLOCK_DATA holds a freshly ticked value, so loads never match.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            alarm_match_q <= 1'b0;
        end else begin
            alarm_match_q <= sec_tick_q & bus.ALARM_ARM & (cur_q == tod_t'(bus.ALARM_DATA));
        end
    end

    assign bus.ALARM_MATCH = alarm_match_q;
`endif

endmodule
